// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data SRAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IM,
        OWN_DM
    } owner_e;

    localparam logic [3:0] WEB_READ = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IM port, DM port and SRAM command/data signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic                  im_req;
    logic [31:0]           im_addr;
    logic                  im_ready;
    logic                  im_valid;
    logic [DATA_W-1:0]     im_rdata;

    logic                  dm_req;
    logic [DATA_W/8-1:0]   dm_web;
    logic [31:0]           dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_ready;
    logic                  dm_valid;
    logic [DATA_W-1:0]     dm_rdata;

    logic                  sram_cs;
    logic                  sram_oe;
    logic [DATA_W/8-1:0]   sram_web;
    logic [ADDR_W-1:0]     sram_a;
    logic [DATA_W-1:0]     sram_di;
    logic [DATA_W-1:0]     sram_do;

    // Arbiter side.
    modport slave (
        input  im_req, im_addr, dm_req, dm_web, dm_addr, dm_wdata, sram_do,
        output im_ready, im_valid, im_rdata, dm_ready, dm_valid, dm_rdata,
        output sram_cs, sram_oe, sram_web, sram_a, sram_di
    );

    // Core + SRAM side.
    modport master (
        output im_req, im_addr, dm_req, dm_web, dm_addr, dm_wdata, sram_do,
        input  im_ready, im_valid, im_rdata, dm_ready, dm_valid, dm_rdata,
        input  sram_cs, sram_oe, sram_web, sram_a, sram_di
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational two-requester picker. ARB_RR_EN selects round-robin on conflicts;
// otherwise DM always beats IM.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   im_req,
    input  logic   dm_req,
    input  logic   last_q,   // 1: DM won the last conflict, 0: IM won it
    output owner_e owner
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        owner = OWN_NONE;
        if (im_req && dm_req) begin
`ifdef ARB_RR_EN
            owner = last_q ? OWN_IM : OWN_DM;
`else
            owner = OWN_DM;
`endif
        end else if (dm_req) begin
            owner = OWN_DM;
        end else if (im_req) begin
            owner = OWN_IM;
        end
    end

`ifndef ARB_RR_EN
    logic unused_last;
    assign unused_last = last_q;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and MEM-stage data access.
// Define ARB_RR_EN for round-robin conflict resolution (default: DM over IM).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    owner_e            winner;
    owner_e            resp_d, resp_q;
    logic              resp_rd_d, resp_rd_q;
    logic [DATA_W-1:0] im_hold_d, im_hold_q;
    logic [DATA_W-1:0] dm_hold_d, dm_hold_q;
    logic              last_q;

    arb_pick u_pick (
        .im_req (bus.im_req),
        .dm_req (bus.dm_req),
        .last_q (last_q),
        .owner  (winner)
    );

`ifdef ARB_RR_EN
    logic last_d;

    // Priority only flips on conflict cycles; lone grants leave it alone.
    always_comb begin
        last_d = last_q;
        if (bus.im_req && bus.dm_req) begin
            last_d = (winner == OWN_DM);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign last_q = 1'b0;
`endif

    // SRAM command and grants follow the winner with no register in between.
    always_comb begin
        bus.im_ready = (winner == OWN_IM);
        bus.dm_ready = (winner == OWN_DM);
        bus.sram_cs  = 1'b0;
        bus.sram_web = WEB_READ;
        bus.sram_a   = '0;
        bus.sram_di  = '0;
        unique case (winner)
            OWN_IM: begin
                bus.sram_cs = 1'b1;
                bus.sram_a  = bus.im_addr[ADDR_W+1:2];
            end
            OWN_DM: begin
                bus.sram_cs  = 1'b1;
                bus.sram_web = bus.dm_web;
                bus.sram_a   = bus.dm_addr[ADDR_W+1:2];
                bus.sram_di  = bus.dm_wdata;
            end
            default: ;
        endcase
        bus.sram_oe = bus.sram_cs && (bus.sram_web == WEB_READ);
    end

    always_comb begin
        resp_d    = winner;
        resp_rd_d = bus.sram_oe;
        im_hold_d = im_hold_q;
        dm_hold_d = dm_hold_q;
        if (resp_q == OWN_IM) begin
            im_hold_d = bus.sram_do;
        end
        if (resp_q == OWN_DM && resp_rd_q) begin
            dm_hold_d = bus.sram_do;
        end
    end

    // Read data passes straight through in the response cycle, then is held.
    always_comb begin
        bus.im_valid = (resp_q == OWN_IM);
        bus.dm_valid = (resp_q == OWN_DM);
        bus.im_rdata = im_hold_d;
        bus.dm_rdata = dm_hold_d;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the rdata holding registers are reset because the ports must read 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_q    <= OWN_NONE;
            resp_rd_q <= 1'b0;
            im_hold_q <= '0;
            dm_hold_q <= '0;
        end else begin
            resp_q    <= resp_d;
            resp_rd_q <= resp_rd_d;
            im_hold_q <= im_hold_d;
            dm_hold_q <= dm_hold_d;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.im_addr[31:ADDR_W+2], bus.im_addr[1:0],
                                bus.dm_addr[31:ADDR_W+2], bus.dm_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus corner-case sequences,
// with an SRAM model and a response scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        string       name;
        logic        im_req;
        logic [31:0] im_addr;
        logic        dm_req;
        logic [3:0]  dm_web;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        exp_cs;
        logic        exp_oe;
        logic [3:0]  exp_web;
        logic [13:0] exp_a;
        logic [31:0] exp_di;
    } vec_t;

    typedef struct {
        owner_e      own;
        bit          is_wr;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] init_word(input logic [13:0] a);
        logic [15:0] w;
        w = {2'b00, a};
        return (a == 14'd4) ? 32'hDEADBEEF : {w ^ 16'h5A5A, ~w};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                          input logic [3:0] web);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (!web[b]) r[b*8 +: 8] = di[b*8 +: 8];
        return r;
    endfunction

    // SRAM model: registered read, byte-masked write.
    logic [31:0] sram_mem [DEPTH];
    bit          sram_wr  [DEPTH];
    logic [31:0] sram_do_q;

    function automatic logic [31:0] sram_word(input logic [13:0] a);
        return sram_wr[a] ? sram_mem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (bus.sram_cs) begin
            if (bus.sram_web == 4'hF) begin
                sram_do_q <= sram_word(bus.sram_a);
            end else begin
                sram_mem[bus.sram_a] <= merge(sram_word(bus.sram_a), bus.sram_di, bus.sram_web);
                sram_wr[bus.sram_a]  <= 1'b1;
            end
        end
    end
    assign bus.sram_do = sram_do_q;

    // Reference memory, updated when a write is issued.
    logic [31:0] ref_mem [DEPTH];
    bit          ref_wr  [DEPTH];

    function automatic logic [31:0] ref_word(input logic [13:0] a);
        return ref_wr[a] ? ref_mem[a] : init_word(a);
    endfunction

    resp_t       sb_q[$];
    bit          model_last_dm;
    logic [31:0] exp_im_hold;
    logic [31:0] exp_dm_hold;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.im_req   = v.im_req;
        bus.im_addr  = v.im_addr;
        bus.dm_req   = v.dm_req;
        bus.dm_web   = v.dm_web;
        bus.dm_addr  = v.dm_addr;
        bus.dm_wdata = v.dm_wdata;
    endtask

    task automatic model_grant(input logic im, input logic dm, output owner_e w);
        w = OWN_NONE;
        if (im && dm) begin
`ifdef ARB_RR_EN
            w = model_last_dm ? OWN_IM : OWN_DM;
            model_last_dm = (w == OWN_DM);
`else
            w = OWN_DM;
`endif
        end else if (dm) begin
            w = OWN_DM;
        end else if (im) begin
            w = OWN_IM;
        end
    endtask

    task automatic push_expect(input owner_e w, input vec_t v);
        resp_t       e;
        logic [13:0] a;
        e.own   = w;
        e.is_wr = 1'b0;
        e.data  = '0;
        if (w == OWN_IM) begin
            e.data = ref_word(v.im_addr[15:2]);
        end else if (w == OWN_DM) begin
            a = v.dm_addr[15:2];
            if (v.dm_web == 4'hF) begin
                e.data = ref_word(a);
            end else begin
                e.is_wr   = 1'b1;
                ref_mem[a] = merge(ref_word(a), v.dm_wdata, v.dm_web);
                ref_wr[a]  = 1'b1;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        e.own = OWN_NONE; e.is_wr = 1'b0; e.data = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        check({tag, ".im_valid"}, bus.im_valid, e.own == OWN_IM);
        if (e.own == OWN_IM) exp_im_hold = e.data;
        check({tag, ".im_rdata"}, bus.im_rdata, exp_im_hold);
        check({tag, ".dm_valid"}, bus.dm_valid, e.own == OWN_DM);
        if (e.own == OWN_DM && !e.is_wr) exp_dm_hold = e.data;
        check({tag, ".dm_rdata"}, bus.dm_rdata, exp_dm_hold);
    endtask

    // One cycle: drive at negedge, check previous response and this cycle's grant/command.
    task automatic step(input vec_t v, input bit chk_cmd);
        owner_e w;
        @(negedge clk);
        drive(v);
        #1;
        check_resp(v.name);
        model_grant(v.im_req, v.dm_req, w);
        check({v.name, ".im_ready"}, bus.im_ready, w == OWN_IM);
        check({v.name, ".dm_ready"}, bus.dm_ready, w == OWN_DM);
        if (chk_cmd) begin
            check({v.name, ".cs"},  bus.sram_cs,  v.exp_cs);
            check({v.name, ".oe"},  bus.sram_oe,  v.exp_oe);
            check({v.name, ".web"}, bus.sram_web, v.exp_web);
            check({v.name, ".a"},   bus.sram_a,   v.exp_a);
            check({v.name, ".di"},  bus.sram_di,  v.exp_di);
        end
        push_expect(w, v);
    endtask

    function automatic vec_t mk(input string n, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic [3:0] dw, input logic [31:0] da,
                                input logic [31:0] dd, input logic cs, input logic oe,
                                input logic [3:0] web, input logic [13:0] a,
                                input logic [31:0] di);
        vec_t v;
        v.name = n; v.im_req = ir; v.im_addr = ia; v.dm_req = dr; v.dm_web = dw;
        v.dm_addr = da; v.dm_wdata = dd; v.exp_cs = cs; v.exp_oe = oe;
        v.exp_web = web; v.exp_a = a; v.exp_di = di;
        return v;
    endfunction

    function automatic vec_t im_rd(input string n, input logic [31:0] addr);
        return mk(n, 1, addr, 0, 4'hF, 0, 0, 1, 1, 4'hF, addr[15:2], 0);
    endfunction

    vec_t vecs[10];
    vec_t idle;
    vec_t both;

    initial begin
        idle = mk("idle", 0, 0, 0, 4'hF, 0, 0, 0, 0, 4'hF, 0, 0);
        vecs[0] = im_rd("im_rd_10", 32'h10);
        vecs[1] = mk("dm_st_20",  0, 0, 1, 4'b1100, 32'h20, 32'h1234_5678, 1, 0, 4'b1100, 14'd8, 32'h1234_5678);
        vecs[2] = mk("dm_ld_20",  0, 0, 1, 4'hF, 32'h20, 0, 1, 1, 4'hF, 14'd8, 0);
        vecs[3] = idle;
        vecs[4] = im_rd("im_wrap", 32'h0001_001B);
        vecs[5] = mk("dm_ld_top", 0, 0, 1, 4'hF, 32'hFFFF_FFFC, 0, 1, 1, 4'hF, 14'h3FFF, 0);
        vecs[6] = mk("dm_st_30",  0, 0, 1, 4'b0000, 32'h30, 32'hCAFE_F00D, 1, 0, 4'b0000, 14'd12, 32'hCAFE_F00D);
        vecs[7] = im_rd("im_rd_30", 32'h30);
        vecs[8] = mk("dm_sb_33",  0, 0, 1, 4'b0111, 32'h33, 32'hAB00_0000, 1, 0, 4'b0111, 14'd12, 32'hAB00_0000);
        vecs[9] = mk("dm_ld_30",  0, 0, 1, 4'hF, 32'h30, 0, 1, 1, 4'hF, 14'd12, 0);
        both = mk("conflict", 1, 32'h40, 1, 4'hF, 32'h44, 0, 0, 0, 4'hF, 0, 0);

        model_last_dm = 1'b0;
        exp_im_hold   = '0;
        exp_dm_hold   = '0;
        rst = 1'b0;
        drive(idle);
        repeat (2) @(negedge clk);
        #1;
        check("reset.im_valid", bus.im_valid, 0);
        check("reset.dm_valid", bus.dm_valid, 0);
        check("reset.im_rdata", bus.im_rdata, 0);
        check("reset.dm_rdata", bus.dm_rdata, 0);
        check("reset.sram_cs",  bus.sram_cs,  0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) step(vecs[i], 1'b1);
        step(idle, 1'b1);

        // Both ports requesting for four cycles.
        repeat (4) step(both, 1'b0);
        step(idle, 1'b0);

        // Back-to-back instruction fetches.
        for (int i = 0; i < 3; i++) step(im_rd("im_b2b", 32'(i * 4)), 1'b1);
        step(idle, 1'b0);

        // Reset lands while a DM read response is due.
        step(vecs[2], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(im_rd("rst_req", 32'h10));
        #1;
        check("rst_mid.dm_valid", bus.dm_valid, 0);
        check("rst_mid.dm_rdata", bus.dm_rdata, 0);
        check("rst_mid.im_rdata", bus.im_rdata, 0);
        check("rst_mid.sram_cs",  bus.sram_cs,  1);
        check("rst_mid.sram_a",   bus.sram_a,   14'd4);
        drive(idle);
        #1;
        check("rst_idle.sram_cs", bus.sram_cs, 0);
        sb_q.delete();
        model_last_dm = 1'b0;
        exp_im_hold   = '0;
        exp_dm_hold   = '0;
        @(negedge clk);
        rst = 1'b1;
        step(idle, 1'b0);
        step(vecs[0], 1'b1);
        step(idle, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
